frac_reducer: RTL and testbench
===============================

Name: frac_reducer

Overview:
- Downstream consumer of the ebob GCD unit.
- Accepts a fraction num/den plus its GCD, as produced by ebob, over a valid/ready handshake.
- Divides both terms by the GCD using one shared sequential restoring divider and returns the reduced fraction.
- Used to normalise ratios before display or further arithmetic.

Parameters:
- WIDTH, 4, bit width of num, den, gcd and quotients (matches ebob's 4-bit operands).

Ports:
- clk  in  1  system clock, rising edge.
- clkrst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block can accept operands.
- in_num  in  WIDTH  numerator (ebob numb1).
- in_den  in  WIDTH  denominator (ebob numb2).
- in_gcd  in  WIDTH  GCD from ebob (ebobb).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_num  out  WIDTH  in_num / in_gcd.
- out_den  out  WIDTH  in_den / in_gcd.
- out_err  out  1  gcd zero or non-exact division.
- out_lcm  out  2*WIDTH  least common multiple (see Optional Feature).

Behaviour:
- Reset (clkrst=0, async): state=IDLE, in_ready=0 during reset, out_valid=0, out_num=0, out_den=0, out_err=0, out_lcm=0, internal regs 0.
- in_ready=1 only in IDLE with clkrst=1. Combinational from state.
- States:
  - IDLE: on in_valid&&in_ready, latch num/den/gcd, clear err.
    - If gcd==0: out_num=in_num, out_den=in_den, out_err=1, go to DONE.
    - Otherwise go to DIV_N with bit counter=WIDTH-1.
  - DIV_N: one restoring-division step per clock, MSB first.
    - rem = {rem, dividend bit}; if rem >= gcd then subtract gcd and set quotient bit.
    - After WIDTH steps, store quotient in out_num and go to DIV_D.
    - Nonzero final remainder sets out_err.
  - DIV_D: same as DIV_N for den, store quotient in out_den.
    - Next state is DONE, or LCM when FRAC_LCM_EN is defined.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid on the same edge.
- Latency (no LCM): out_valid rises 2*WIDTH clocks after the accept edge (WIDTH=4 gives 8).
- gcd==0 path: out_valid rises 1 clock after the accept edge.
- No overlap: one transaction in flight. in_ready is low from the accept edge until the edge after the output handshake completes.
- Arithmetic is unsigned. Quotient is never wider than WIDTH. Remainder register is WIDTH+1 bits to hold the pre-subtract value.
- num=0: quotient 0, err=0. gcd=1: quotients equal inputs.
- Reset asserted mid-operation aborts the transaction with no partial output. After release, the block is in IDLE with in_ready=1.
- Input changes outside the accept edge are ignored.

Optional Feature:
- Macro: FRAC_LCM_EN.
- Defined:
  - Adds state LCM after DIV_D: shift-add multiply out_num*in_den, WIDTH clocks, LSB first.
  - out_lcm = (num/gcd)*den, 2*WIDTH bits.
  - Latency becomes 3*WIDTH clocks.
  - If err is set, LCM is skipped and out_lcm=0.
- Undefined: no LCM state, out_lcm tied to 0, latency 2*WIDTH.

Test Plan:
- num=15, den=10, gcd=5 -> after 8 clks out_num=3, out_den=2, err=0. With FRAC_LCM_EN: out_lcm=30 after 12 clks.
- num=12, den=8, gcd=4, out_ready held 0 for 5 clks -> out_valid stays 1 with 3/2 stable. in_ready=0 throughout. Releasing out_ready returns to IDLE next edge.
- num=7, den=5, gcd=0 -> out_valid 1 clk after accept, out_num=7, out_den=5, err=1, out_lcm=0.
- num=10, den=6, gcd=3 (wrong GCD) -> out_num=3, out_den=2, err=1.
- Drive clkrst=0 during DIV_D of 15/10/5 -> all outputs 0 immediately, without waiting for a clock edge. After release, in_ready=1. A new 9/6/3 yields 3/2.
- Back-to-back: in_valid held 1 with two operand sets (15/10/5 then 0/9/9) -> second accepted only after the first output handshake. Results 3/2 then 0/1, err=0.

Source files
------------

// File: rtl/frac_reducer.sv
// frac_reducer: divides a fraction num/den by a supplied GCD and returns the
// reduced terms. One shared restoring divider handles the numerator and then
// the denominator, one quotient bit per clock, MSB first.
// Optional build macro FRAC_LCM_EN adds a shift-add multiply stage that
// produces out_lcm = (num/gcd)*den; without it out_lcm is tied to zero.
module frac_reducer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               clkrst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_num,
   input  logic [WIDTH-1:0]   in_den,
   input  logic [WIDTH-1:0]   in_gcd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_num,
   output logic [WIDTH-1:0]   out_den,
   output logic               out_err,
   output logic [2*WIDTH-1:0] out_lcm
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StDivN, StDivD, StLcm, StDone} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_num;
   logic [WIDTH-1:0] r_den;
   logic [WIDTH-1:0] r_gcd;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH:0]   r_rem;
   logic [CW-1:0]    r_cnt;
   logic             r_out_valid;
   logic             r_out_err;
   logic [WIDTH-1:0] r_out_num;
   logic [WIDTH-1:0] r_out_den;

   logic [WIDTH-1:0] w_dividend;
   logic [WIDTH:0]   w_rem_shift;
   logic [WIDTH:0]   w_rem_next;
   logic             w_q_bit;
   logic [WIDTH-1:0] w_quo_next;
   logic             w_last;
   logic             w_err_next;

`ifdef FRAC_LCM_EN
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_out_lcm;
   logic [CW-1:0]      w_lcm_idx;
   logic [2*WIDTH-1:0] w_acc_next;

   // One shift-add multiply step: multiplier bits of den consumed LSB first.
   always_comb begin
      w_lcm_idx  = CntLast - r_cnt;
      w_acc_next = r_acc + (r_den[w_lcm_idx] ? r_mcand : '0);
   end

   assign out_lcm = r_out_lcm;
`else
   assign out_lcm = '0;
`endif

   // One restoring-division step on whichever term is currently being divided.
   always_comb begin
      w_dividend  = (r_state == StDivD) ? r_den : r_num;
      // Remainder is always below gcd, so the shift never loses a set bit.
      w_rem_shift = (r_rem << 1) | {{WIDTH{1'b0}}, w_dividend[r_cnt]};
      w_q_bit     = (w_rem_shift >= {1'b0, r_gcd});
      w_rem_next  = w_q_bit ? (w_rem_shift - {1'b0, r_gcd}) : w_rem_shift;
      w_quo_next  = WIDTH'({r_quo, w_q_bit});
      w_last      = (r_cnt == '0);
      w_err_next  = r_out_err | (w_rem_next != '0);
   end

   assign in_ready  = (r_state == StIdle) && clkrst;
   assign out_valid = r_out_valid;
   assign out_num   = r_out_num;
   assign out_den   = r_out_den;
   assign out_err   = r_out_err;

   // Control FSM with registered outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge clkrst) begin
      if (!clkrst) begin
         r_state     <= StIdle;
         r_num       <= '0;
         r_den       <= '0;
         r_gcd       <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_num   <= '0;
         r_out_den   <= '0;
`ifdef FRAC_LCM_EN
         r_mcand     <= '0;
         r_acc       <= '0;
         r_out_lcm   <= '0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_num     <= in_num;
                  r_den     <= in_den;
                  r_gcd     <= in_gcd;
                  r_quo     <= '0;
                  r_rem     <= '0;
                  r_cnt     <= CntLast;
                  r_out_err <= 1'b0;
`ifdef FRAC_LCM_EN
                  r_acc     <= '0;
                  r_out_lcm <= '0;
`endif
                  if (in_gcd == '0) begin
                     // Nothing to divide by: pass the fraction through flagged.
                     r_out_num <= in_num;
                     r_out_den <= in_den;
                     r_out_err <= 1'b1;
                     r_state   <= StDone;
                  end else begin
                     r_state <= StDivN;
                  end
               end
            end
            StDivN: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt - 1'b1;
               if (w_last) begin
                  r_out_num <= w_quo_next;
                  r_out_err <= w_err_next;
                  r_rem     <= '0;
                  r_quo     <= '0;
                  r_cnt     <= CntLast;
                  r_state   <= StDivD;
               end
            end
            StDivD: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt - 1'b1;
               if (w_last) begin
                  r_out_den <= w_quo_next;
                  r_out_err <= w_err_next;
                  r_rem     <= '0;
                  r_quo     <= '0;
                  r_cnt     <= CntLast;
`ifdef FRAC_LCM_EN
                  if (w_err_next) begin
                     r_out_valid <= 1'b1;
                     r_state     <= StDone;
                  end else begin
                     r_mcand <= {{WIDTH{1'b0}}, r_out_num};
                     r_acc   <= '0;
                     r_state <= StLcm;
                  end
`else
                  r_out_valid <= 1'b1;
                  r_state     <= StDone;
`endif
               end
            end
`ifdef FRAC_LCM_EN
            StLcm: begin
               r_acc   <= w_acc_next;
               r_mcand <= r_mcand << 1;
               r_cnt   <= r_cnt - 1'b1;
               if (w_last) begin
                  r_out_lcm   <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_cnt       <= CntLast;
                  r_state     <= StDone;
               end
            end
`endif
            StDone: begin
               // The gcd==0 shortcut arrives here with valid still low.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_frac_reducer.sv
// Self-checking bench for frac_reducer: directed table, hand-written
// reset/back-to-back sequences and randomized transactions against a
// plain-arithmetic reference model.
module tb_frac_reducer;

   localparam int W = 4;
`ifdef FRAC_LCM_EN
   localparam bit LcmEn = 1'b1;
`else
   localparam bit LcmEn = 1'b0;
`endif

   logic           clk;
   logic           clkrst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_num;
   logic [W-1:0]   in_den;
   logic [W-1:0]   in_gcd;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_num;
   logic [W-1:0]   out_den;
   logic           out_err;
   logic [2*W-1:0] out_lcm;

   int n_tests = 0;
   int n_fail  = 0;

   frac_reducer #(.WIDTH(W)) dut (
      .clk       (clk),
      .clkrst    (clkrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .in_den    (in_den),
      .in_gcd    (in_gcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_num   (out_num),
      .out_den   (out_den),
      .out_err   (out_err),
      .out_lcm   (out_lcm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int num;
      int den;
      int gcd;
      int exp_num;
      int exp_den;
      int exp_err;
      int lcm_en;   // out_lcm expected when the multiply stage is built in
      int hold;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int gcd_of(input int a, input int b);
      int x = a;
      int y = b;
      while (y != 0) begin
         int t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Reference model straight from the arithmetic definition.
   function automatic void model(input int n, input int d, input int g,
                                 output int en, output int ed, output int ee,
                                 output int el, output int lat);
      if (g == 0) begin
         en = n; ed = d; ee = 1; el = 0; lat = 1;
      end else begin
         en  = n / g;
         ed  = d / g;
         ee  = ((n % g) != 0 || (d % g) != 0) ? 1 : 0;
         el  = (LcmEn && ee == 0) ? en * d : 0;
         lat = (LcmEn && ee == 0) ? 3 * W : 2 * W;
      end
   endfunction

   // Called at a falling edge right after the accept edge; returns cycles to out_valid.
   task automatic wait_valid(input string name, output int k);
      bit ready_bad = 0;
      k = 0;
      while (out_valid !== 1'b1 && k < 40) begin
         if (in_ready !== 1'b0) ready_bad = 1;
         @(negedge clk);
         k++;
      end
      check({name, "/busy_ready_low"}, 32'(ready_bad), 32'd0);
   endtask

   task automatic check_result(input string name, input int en, input int ed,
                               input int ee, input int el);
      check({name, "/valid"}, 32'(out_valid), 32'd1);
      check({name, "/num"}, 32'(out_num), 32'(en));
      check({name, "/den"}, 32'(out_den), 32'(ed));
      check({name, "/err"}, 32'(out_err), 32'(ee));
      check({name, "/lcm"}, 32'(out_lcm), 32'(el));
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "/valid_drop"}, 32'(out_valid), 32'd0);
      check({name, "/ready_back"}, 32'(in_ready), 32'd1);
   endtask

   // Full transaction; entered and left at a falling edge with the block idle.
   task automatic do_txn(input string name, input int n, input int d, input int g,
                         input int en, input int ed, input int ee, input int el,
                         input int lat, input int hold);
      int k;
      check({name, "/idle_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_num = W'(n);
      in_den = W'(d);
      in_gcd = W'(g);
      @(negedge clk);
      in_valid = 1'b0;
      in_num = W'($urandom);
      in_den = W'($urandom);
      in_gcd = W'($urandom);
      wait_valid(name, k);
      check({name, "/latency"}, 32'(k), 32'(lat));
      check_result(name, en, ed, ee, el);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "/hold_valid"}, 32'(out_valid), 32'd1);
         check({name, "/hold_num"}, 32'(out_num), 32'(en));
         check({name, "/hold_den"}, 32'(out_den), 32'(ed));
         check({name, "/hold_ready"}, 32'(in_ready), 32'd0);
      end
      handshake(name);
   endtask

   initial begin
      int en, ed, ee, el, lat, k;

      vecs[0] = '{15, 10, 5, 3, 2, 0, 30, 0};
      vecs[1] = '{12, 8, 4, 3, 2, 0, 24, 5};
      vecs[2] = '{7, 5, 0, 7, 5, 1, 0, 0};
      vecs[3] = '{10, 6, 3, 3, 2, 1, 0, 0};
      vecs[4] = '{0, 9, 9, 0, 1, 0, 0, 0};
      vecs[5] = '{13, 7, 1, 13, 7, 0, 91, 1};
      vecs[6] = '{15, 15, 15, 1, 1, 0, 15, 0};

      clkrst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_num = '0;
      in_den = '0;
      in_gcd = '0;
      #1;
      check("reset/in_ready", 32'(in_ready), 32'd0);
      check("reset/out_valid", 32'(out_valid), 32'd0);
      check("reset/out_num", 32'(out_num), 32'd0);
      check("reset/out_den", 32'(out_den), 32'd0);
      check("reset/out_err", 32'(out_err), 32'd0);
      check("reset/out_lcm", 32'(out_lcm), 32'd0);
      repeat (2) @(negedge clk);
      clkrst = 1'b1;
      @(negedge clk);

      // Directed table; expected latency follows the gcd==0 / error / LCM rules.
      for (int i = 0; i < 7; i++) begin
         int exp_lcm;
         int exp_lat;
         exp_lcm = (LcmEn && vecs[i].exp_err == 0) ? vecs[i].lcm_en : 0;
         if (vecs[i].gcd == 0) exp_lat = 1;
         else if (LcmEn && vecs[i].exp_err == 0) exp_lat = 3 * W;
         else exp_lat = 2 * W;
         do_txn($sformatf("vec%0d", i), vecs[i].num, vecs[i].den, vecs[i].gcd,
                vecs[i].exp_num, vecs[i].exp_den, vecs[i].exp_err, exp_lcm,
                exp_lat, vecs[i].hold);
      end

      // Reset asserted while the denominator is being divided.
      in_valid = 1'b1;
      in_num = 4'd15;
      in_den = 4'd10;
      in_gcd = 4'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("midreset/num_before", 32'(out_num), 32'd3);
      clkrst = 1'b0;
      #1;
      check("midreset/out_valid", 32'(out_valid), 32'd0);
      check("midreset/out_num", 32'(out_num), 32'd0);
      check("midreset/out_den", 32'(out_den), 32'd0);
      check("midreset/out_err", 32'(out_err), 32'd0);
      check("midreset/out_lcm", 32'(out_lcm), 32'd0);
      check("midreset/in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      clkrst = 1'b1;
      @(negedge clk);
      check("midreset/ready_after", 32'(in_ready), 32'd1);
      check("midreset/valid_after", 32'(out_valid), 32'd0);
      model(9, 6, 3, en, ed, ee, el, lat);
      do_txn("after_reset", 9, 6, 3, en, ed, ee, el, lat, 0);

      // Back-to-back: second set waits behind the first output handshake.
      in_valid = 1'b1;
      in_num = 4'd15;
      in_den = 4'd10;
      in_gcd = 4'd5;
      @(negedge clk);
      in_num = 4'd0;
      in_den = 4'd9;
      in_gcd = 4'd9;
      wait_valid("b2b_first", k);
      model(15, 10, 5, en, ed, ee, el, lat);
      check("b2b_first/latency", 32'(k), 32'(lat));
      check_result("b2b_first", en, ed, ee, el);
      repeat (2) begin
         @(negedge clk);
         check("b2b_first/hold_ready", 32'(in_ready), 32'd0);
      end
      handshake("b2b_first");
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_second/accepted", 32'(in_ready), 32'd0);
      wait_valid("b2b_second", k);
      model(0, 9, 9, en, ed, ee, el, lat);
      check("b2b_second/latency", 32'(k), 32'(lat));
      check_result("b2b_second", en, ed, ee, el);
      handshake("b2b_second");

      // Randomized transactions: true GCD, arbitrary divisor, or zero.
      for (int i = 0; i < 40; i++) begin
         int n, d, g, mode;
         n = int'($urandom_range(0, 15));
         d = int'($urandom_range(0, 15));
         mode = int'($urandom_range(0, 3));
         if (mode == 0) g = 0;
         else if (mode == 1) g = gcd_of(n, d);
         else g = int'($urandom_range(1, 15));
         model(n, d, g, en, ed, ee, el, lat);
         do_txn($sformatf("rand%0d_%0d/%0d/%0d", i, n, d, g), n, d, g,
                en, ed, ee, el, lat, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
